// File: rtl/ln_iter.sv
// Sequential natural logarithm: power-of-two range reduction
// followed by an atanh series evaluated one term per cycle.
module ln_iter #(
   parameter int TERMS = 21
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  real  in_val,
   output logic busy,
   output logic done,
   output real  out_val,
   output logic err
);

   localparam real LN2 = 0.6931471805599453;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      PREP,
      SERIES
   } state_t;

   state_t state_q;
   real    x_q, y_q, ysq_q, pw_q, sum_q, out_q;
   int     k_q, n_q;
   logic   busy_q, done_q, err_q;
   real    sum_d, y_d;

   // Next partial sum and the reduced atanh argument.
   always_comb begin
      sum_d = sum_q + pw_q / real'(2 * n_q + 1);
      y_d   = (x_q - 1.0) / (x_q + 1.0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= 0.0;
         y_q     <= 0.0;
         ysq_q   <= 0.0;
         pw_q    <= 0.0;
         sum_q   <= 0.0;
         out_q   <= 0.0;
         k_q     <= 0;
         n_q     <= 0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (in_val <= 0.0) begin
                     err_q  <= 1'b1;
                     out_q  <= 0.0;
                     done_q <= 1'b1;
                  end else begin
                     x_q     <= in_val;
                     k_q     <= 0;
                     busy_q  <= 1'b1;
                     state_q <= NORM;
                  end
               end
            end
            NORM: begin
               if (x_q >= 2.0) begin
                  x_q <= x_q / 2.0;
                  k_q <= k_q + 1;
               end else if (x_q < 1.0) begin
                  x_q <= x_q * 2.0;
                  k_q <= k_q - 1;
               end else begin
                  state_q <= PREP;
               end
            end
            PREP: begin
               y_q     <= y_d;
               ysq_q   <= y_d * y_d;
               pw_q    <= y_d;
               sum_q   <= 0.0;
               n_q     <= 0;
               state_q <= SERIES;
            end
            SERIES: begin
               sum_q <= sum_d;
               pw_q  <= pw_q * ysq_q;
               n_q   <= n_q + 1;
               if (n_q + 1 >= TERMS) begin
                  out_q   <= real'(k_q) * LN2 + 2.0 * sum_d;
                  err_q   <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign out_val = out_q;
   assign err     = err_q;

endmodule

// File: tb/tb_ln_iter.sv
// Randomized self-checking bench for ln_iter against a
// reference built from $ln and a known binary exponent.
module tb_ln_iter;

   localparam int TERMS = 21;

   logic clk;
   logic rst_n;
   logic start;
   real  in_val;
   logic busy;
   logic done;
   real  out_val;
   logic err;

   int n_chk;
   int n_fail;

   ln_iter #(.TERMS(TERMS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .in_val (in_val),
      .busy   (busy),
      .done   (done),
      .out_val(out_val),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input real got,
                      input real exp, input real tol);
      real d;
      n_chk++;
      d = got - exp;
      if (d < 0.0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0.15g expected %0.15g", tag, got, exp);
      end
   endtask

   function automatic real ref_tol(input real x);
      real l;
      l = $ln(x);
      if (l < 0.0) l = -l;
      return (l > 1.0) ? 1e-12 * l : 1e-12;
   endfunction

   // One request; k is the binary exponent of x (x = m*2^k, 1<=m<2).
   task automatic run_op(input real x, input int k,
                         input bit poke);
      int  e, lat, bsy, ak;
      bit  bad, seen;
      real exp_v, tol;
      bad   = (x <= 0.0);
      ak    = (k < 0) ? -k : k;
      lat   = bad ? 1 : ak + TERMS + 3;
      exp_v = bad ? 0.0 : $ln(x);
      tol   = bad ? 0.0 : ref_tol(x);
      @(negedge clk);
      in_val = x;
      start  = 1'b1;
      e = 0;
      bsy = 0;
      seen = 1'b0;
      while (!seen && e < 300) begin
         @(posedge clk);
         #1;
         e++;
         start = (poke && !bad && e == 3);
         if (done) seen = 1'b1;
         else if (busy) bsy++;
      end
      chk("latency", real'(e), real'(lat), 0.0);
      chk("busy_cycles", real'(bsy), real'(bad ? 0 : lat - 1), 0.0);
      chk("busy_at_done", real'(busy), 0.0, 0.0);
      chk("err", real'(err), real'(bad), 0.0);
      chk("out_val", out_val, exp_v, tol);
      @(posedge clk);
      #1;
      chk("done_width", real'(done), 0.0, 0.0);
      chk("out_hold", out_val, exp_v, tol);
   endtask

   task automatic b2b();
      int e, nd, last;
      @(negedge clk);
      in_val = 2.718281828459045;
      start  = 1'b1;
      e = 0;
      nd = 0;
      last = 0;
      while (nd < 3 && e < 200) begin
         @(posedge clk);
         #1;
         e++;
         if (done) begin
            nd++;
            chk("b2b_val", out_val, 1.0, 1e-12);
            chk("b2b_gap", real'(e - last), 25.0, 0.0);
            last = e;
            if (nd == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("b2b_count", real'(nd), 3.0, 0.0);
      repeat (2) @(posedge clk);
      #1;
      chk("b2b_idle", real'(busy), 0.0, 0.0);
   endtask

   task automatic mid_reset();
      int nd;
      @(negedge clk);
      in_val = 1.0;
      start  = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_out", out_val, 0.0, 0.0);
      chk("rst_busy", real'(busy), 0.0, 0.0);
      chk("rst_done", real'(done), 0.0, 0.0);
      chk("rst_err", real'(err), 0.0, 0.0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      chk("rst_no_done", real'(nd), 0.0, 0.0);
      chk("rst_out_held", out_val, 0.0, 0.0);
   endtask

   initial begin
      int  ex, r;
      real m, p, x;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      start  = 1'b1;
      in_val = 1.0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", real'(busy), 0.0, 0.0);
      chk("reset_done", real'(done), 0.0, 0.0);
      chk("reset_err", real'(err), 0.0, 0.0);
      chk("reset_out", out_val, 0.0, 0.0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;

      run_op(1.0, 0, 1'b0);
      run_op(8.0, 3, 1'b1);
      run_op(0.25, -2, 1'b0);
      run_op(0.0, 0, 1'b0);
      run_op(-1.0, 0, 1'b0);
      run_op(2.0, 1, 1'b1);
      b2b();
      mid_reset();
      run_op(4.0, 2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         ex = $urandom_range(0, 120) - 60;
         m = 1.0 + real'($urandom) / 4294967296.0;
         p = 1.0;
         if (ex > 0) for (int j = 0; j < ex; j++) p = p * 2.0;
         else for (int j = 0; j < -ex; j++) p = p / 2.0;
         x = m * p;
         if (r == 0) x = -x;
         else if (r == 1) x = 0.0;
         run_op(x, ex, r[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
